uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.

---
 rtl/uart_tx_sched_pkg.sv | 15 +
 rtl/uart_tx_sched_rr_pick.sv | 31 +++
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 tb/tb_uart_tx_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the busy-wait timeout used when the transmitter never acknowledges a start.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } sched_state_t;

  localparam int BUSY_TIMEOUT = 16;
  localparam int TMO_W        = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping at NREQ, with an optional override that keeps a locked requester.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_lockVld,
  input  logic [PTR_W-1:0] i_lockIdx,
  output logic             o_found,
  output logic [PTR_W-1:0] o_idx
);

  // Scan from the farthest slot back to i_ptr so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_found = 1'b1;
        o_idx   = PTR_W'((int'(i_ptr) + k) % NREQ);
      end
    end
    if (i_lockVld && i_req[i_lockIdx]) begin
      o_found = 1'b1;
      o_idx   = i_lockIdx;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte sources.
// Define UART_SCHED_LOCK_EN to let a requester hold the grant across bytes via req_lock.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sch_en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_dat,
  input  logic [NREQ-1:0]   req_chk,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              tx_send,
  output logic [7:0]        tx_dat,
  output logic              tx_chken,
  input  logic              tx_busy,
  output logic              sch_busy
);

  sched_state_t      r_state;
  logic [PTR_W-1:0]  r_rrPtr;
  logic [PTR_W-1:0]  r_gntIdx;
  logic              r_locked;
  logic [TMO_W-1:0]  r_tmoCnt;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_done;
  logic              r_txSend;
  logic [7:0]        r_txDat;
  logic              r_txChken;
  logic              r_schBusy;

  logic              w_found;
  logic [PTR_W-1:0]  w_pickIdx;
  logic              w_lockVld;
  logic              w_holdPtr;
  logic [PTR_W-1:0]  w_nextPtr;
  logic              w_frameEnd;

`ifdef UART_SCHED_LOCK_EN
  assign w_lockVld = r_locked;
  assign w_holdPtr = req_lock[r_gntIdx];
`else
  logic w_unusedLock;
  assign w_unusedLock = ^{req_lock, r_locked};
  assign w_lockVld    = 1'b0;
  assign w_holdPtr    = 1'b0;
`endif

  assign w_nextPtr = (r_gntIdx == PTR_W'(NREQ - 1)) ? '0 : r_gntIdx + 1'b1;

  // A frame ends on busy falling, or when busy never rose within the timeout window.
  assign w_frameEnd = ((r_state == ST_WAIT_HI) && !tx_busy &&
                       (r_tmoCnt == TMO_W'(BUSY_TIMEOUT - 1))) ||
                      ((r_state == ST_WAIT_LO) && !tx_busy);

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req     (req),
    .i_ptr     (r_rrPtr),
    .i_lockVld (w_lockVld),
    .i_lockIdx (r_gntIdx),
    .o_found   (w_found),
    .o_idx     (w_pickIdx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rrPtr   <= '0;
      r_gntIdx  <= '0;
      r_locked  <= 1'b0;
      r_tmoCnt  <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_txSend  <= 1'b0;
      r_txDat   <= '0;
      r_txChken <= 1'b0;
      r_schBusy <= 1'b0;
    end else begin
      r_ack    <= '0;
      r_done   <= '0;
      r_txSend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sch_en && w_found) begin
            r_gntIdx  <= w_pickIdx;
            r_txDat   <= req_dat[8*w_pickIdx +: 8];
            r_txChken <= req_chk[w_pickIdx];
            r_ack     <= NREQ'(1) << w_pickIdx;
            r_locked  <= 1'b0;
            r_schBusy <= 1'b1;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_txSend <= 1'b1;
          r_tmoCnt <= '0;
          r_state  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (!w_frameEnd) begin
            r_tmoCnt <= r_tmoCnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_frameEnd) begin
        r_done    <= NREQ'(1) << r_gntIdx;
        r_rrPtr   <= w_holdPtr ? r_rrPtr : w_nextPtr;
        r_locked  <= w_holdPtr;
        r_schBusy <= 1'b0;
        r_state   <= ST_IDLE;
      end
    end
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign gnt_idx  = r_gntIdx;
  assign tx_send  = r_txSend;
  assign tx_dat   = r_txDat;
  assign tx_chken = r_txChken;
  assign sch_busy = r_schBusy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected grants, a monitor
// checks ack / tx_send / done against them; lock scenario runs with UART_SCHED_LOCK_EN.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sch_en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_dat = '0;
  logic [NREQ-1:0]   req_chk = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [PTR_W-1:0]  gnt_idx;
  logic              tx_send;
  logic [7:0]        tx_dat;
  logic              tx_chken;
  logic              tx_busy = 1'b0;
  logic              sch_busy;

  typedef struct { int idx; logic [7:0] dat; logic chk; } grant_t;
  typedef struct { int idx; int lat; } done_t;

  grant_t expQ[$];
  grant_t sendQ[$];
  done_t  doneQ[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int ackCycle = 0;
  int sendCycle = 0;
  int ackWhileOff = 0;
  int remaining[NREQ] = '{default: 0};
  int sentCnt[NREQ] = '{default: 0};
  logic [7:0] baseDat[NREQ] = '{default: 8'h00};
  logic [NREQ-1:0] chkCfg = '0;
  logic [NREQ-1:0] lockEn = '0;
  int  busyLen = 5;
  bit  stuck = 1'b0;
  int  busyCnt = 0;

  uart_tx_sched #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sch_en   (sch_en),
    .req      (req),
    .req_dat  (req_dat),
    .req_chk  (req_chk),
    .req_lock (req_lock),
    .ack      (ack),
    .done     (done),
    .gnt_idx  (gnt_idx),
    .tx_send  (tx_send),
    .tx_dat   (tx_dat),
    .tx_chken (tx_chken),
    .tx_busy  (tx_busy),
    .sch_busy (sch_busy)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Requesters hold req while bytes remain; each ack advances to the next byte.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] && remaining[i] > 0) begin
        remaining[i]--;
        sentCnt[i]++;
      end
      req[i]            = (remaining[i] > 0);
      req_dat[8*i +: 8] = baseDat[i] + 8'(sentCnt[i]);
      req_chk[i]        = chkCfg[i];
      req_lock[i]       = lockEn[i] && (remaining[i] > 0);
    end
  end

  // Transmitter model: busy for busyLen cycles after a start, or never when stuck.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyCnt = 0;
      tx_busy = 1'b0;
    end else begin
      if (tx_send && !stuck) busyCnt = busyLen;
      tx_busy = (busyCnt > 0);
      if (busyCnt > 0) busyCnt--;
    end
  end

  // Monitor: pops the scoreboard on each ack, start strobe and done pulse.
  always @(negedge clk) begin
    grant_t g;
    done_t  d;
    cycle++;
    if (ack != '0) begin
      if (!sch_en) ackWhileOff++;
      if (expQ.size() == 0) begin
        cmp("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        g = expQ.pop_front();
        cmp("ack_onehot", 32'(ack), 32'(1) << g.idx);
        sendQ.push_back(g);
        ackCycle = cycle;
      end
    end
    if (tx_send) begin
      if (sendQ.size() == 0) begin
        cmp("unexpected_send", 32'(tx_send), 32'h0);
      end else begin
        g = sendQ.pop_front();
        cmp("tx_dat", 32'(tx_dat), 32'(g.dat));
        cmp("tx_chken", 32'(tx_chken), 32'(g.chk));
        cmp("gnt_idx", 32'(gnt_idx), 32'(g.idx));
        cmp("send_latency", 32'(cycle - ackCycle), 32'd1);
        d.idx = g.idx;
        d.lat = stuck ? 16 : 0;
        doneQ.push_back(d);
        sendCycle = cycle;
      end
    end
    if (done != '0) begin
      if (doneQ.size() == 0) begin
        cmp("unexpected_done", 32'(done), 32'h0);
      end else begin
        d = doneQ.pop_front();
        cmp("done_onehot", 32'(done), 32'(1) << d.idx);
        if (d.lat != 0) cmp("timeout_latency", 32'(cycle - sendCycle), 32'(d.lat));
      end
    end
  end

  task automatic expectGrant(int i, logic [7:0] d, logic c);
    grant_t g;
    g.idx = i;
    g.dat = d;
    g.chk = c;
    expQ.push_back(g);
  endtask

  task automatic applyStimulus(int i, int n, logic [7:0] base, logic chk, logic lk);
    remaining[i] = n;
    sentCnt[i]   = 0;
    baseDat[i]   = base;
    chkCfg[i]    = chk;
    lockEn[i]    = lk;
  endtask

  task automatic checkOutput(string tag);
    cmp({tag, "_ack"}, 32'(ack), 32'h0);
    cmp({tag, "_done"}, 32'(done), 32'h0);
    cmp({tag, "_gnt_idx"}, 32'(gnt_idx), 32'h0);
    cmp({tag, "_tx_send"}, 32'(tx_send), 32'h0);
    cmp({tag, "_tx_dat"}, 32'(tx_dat), 32'h0);
    cmp({tag, "_tx_chken"}, 32'(tx_chken), 32'h0);
    cmp({tag, "_sch_busy"}, 32'(sch_busy), 32'h0);
  endtask

  function automatic bit idleNow();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += remaining[i];
    return (expQ.size() == 0) && (sendQ.size() == 0) && (doneQ.size() == 0) &&
           !sch_busy && (s == 0);
  endfunction

  task automatic waitIdle(string tag, int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (idleNow()) break;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitSignal(string tag, bit wantSend, int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (wantSend ? tx_send : (ack != '0)) break;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: event missing after %0d cycles", tag, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset");
    @(posedge clk); #2;
    rst_n  = 1'b1;
    sch_en = 1'b1;

    // Single requester 2
    expectGrant(2, 8'hA5, 1'b1);
    @(posedge clk); #2;
    applyStimulus(2, 1, 8'hA5, 1'b1, 1'b0);
    waitIdle("t1", 100);

    // Reset to bring the pointer back to 0, then all four requesting
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset2");
    @(posedge clk); #2;
    rst_n = 1'b1;
    expectGrant(0, 8'h10, 1'b1);
    expectGrant(1, 8'h20, 1'b0);
    expectGrant(2, 8'h30, 1'b1);
    expectGrant(3, 8'h40, 1'b0);
    expectGrant(0, 8'h11, 1'b1);
    @(posedge clk); #2;
    applyStimulus(0, 2, 8'h10, 1'b1, 1'b0);
    applyStimulus(1, 1, 8'h20, 1'b0, 1'b0);
    applyStimulus(2, 1, 8'h30, 1'b1, 1'b0);
    applyStimulus(3, 1, 8'h40, 1'b0, 1'b0);
    waitIdle("t2", 300);

    // Transmitter never raises busy: timeout completes the frame
    stuck = 1'b1;
    expectGrant(1, 8'h5C, 1'b0);
    @(posedge clk); #2;
    applyStimulus(1, 1, 8'h5C, 1'b0, 1'b0);
    waitIdle("t3a", 100);
    stuck = 1'b0;
    expectGrant(3, 8'h3C, 1'b1);
    @(posedge clk); #2;
    applyStimulus(3, 1, 8'h3C, 1'b1, 1'b0);
    waitIdle("t3b", 100);

    // Enable dropped mid-frame
    expectGrant(0, 8'h77, 1'b0);
    @(posedge clk); #2;
    applyStimulus(0, 1, 8'h77, 1'b0, 1'b0);
    waitSignal("t4_ack", 1'b0, 50);
    @(posedge clk); #2;
    sch_en = 1'b0;
    applyStimulus(1, 1, 8'h88, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    cmp("en_off_acks", 32'(ackWhileOff), 32'h0);
    cmp("en_off_done_pending", 32'(doneQ.size()), 32'h0);
    cmp("en_off_sch_busy", 32'(sch_busy), 32'h0);
    expectGrant(1, 8'h88, 1'b0);
    @(posedge clk); #2;
    sch_en = 1'b1;
    waitIdle("t4", 100);

    // Reset while waiting for busy to fall
    busyLen = 20;
    expectGrant(2, 8'hC3, 1'b1);
    @(posedge clk); #2;
    applyStimulus(2, 1, 8'hC3, 1'b1, 1'b0);
    waitSignal("t5_send", 1'b1, 50);
    repeat (3) @(negedge clk);
    cmp("wait_lo_sch_busy", 32'(sch_busy), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset");
    expQ.delete();
    sendQ.delete();
    doneQ.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n   = 1'b1;
    busyLen = 5;
    expectGrant(0, 8'h01, 1'b0);
    expectGrant(3, 8'h03, 1'b1);
    @(posedge clk); #2;
    applyStimulus(0, 1, 8'h01, 1'b0, 1'b0);
    applyStimulus(3, 1, 8'h03, 1'b1, 1'b0);
    waitIdle("t5", 100);

`ifdef UART_SCHED_LOCK_EN
    // Requester 1 locks the grant for its three bytes before 0 gets a turn
    expectGrant(1, 8'hB0, 1'b1);
    expectGrant(1, 8'hB1, 1'b1);
    expectGrant(1, 8'hB2, 1'b1);
    expectGrant(0, 8'hE0, 1'b0);
    expectGrant(0, 8'hE1, 1'b0);
    @(posedge clk); #2;
    applyStimulus(1, 3, 8'hB0, 1'b1, 1'b1);
    waitSignal("t6_ack", 1'b0, 50);
    @(posedge clk); #2;
    applyStimulus(0, 2, 8'hE0, 1'b0, 1'b0);
    waitIdle("t6", 300);
`endif

    cmp("final_expq_empty", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
